// File: rtl/ram_resp_pkg.sv
// Shared definitions for the RAM responder: parameter defaults and FSM state encoding.
package ram_resp_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned RD_LAT_DEF     = 2;

  // Read wait counter covers latencies 0..7.
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STATE_W = 3;

  // FSM state encoding.
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_MAR       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WRITE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_READ_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACK_HOLD  = 3'd4;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM with write enable and registered read; contents are never reset.
module ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on enable; the read port always registers the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM responder: four-phase handshakes for MAR load, RAM write and RAM read.
// Optional feature: define RAM_RESP_PARITY_EN to store an even-parity bit per
// word and report mismatches on par_err alongside read data.
module ram_responder
  import ram_resp_pkg::*;
#(
  parameter int unsigned PA_DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PA_ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned PA_RD_LAT     = RD_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     mar_wr,
  input  logic [PA_ADDR_WIDTH-1:0] addr_in,
  output logic                     mar_wr_ack,
  input  logic                     ram_wr,
  input  logic [PA_DATA_WIDTH-1:0] data_in,
  output logic                     ram_wr_ack,
  input  logic                     ram_oe,
  output logic                     ram_oe_ack,
  output logic [PA_DATA_WIDTH-1:0] data_out,
  output logic                     busy
`ifdef RAM_RESP_PARITY_EN
  ,
  output logic                     par_err
`endif
);

`ifdef RAM_RESP_PARITY_EN
  localparam int unsigned WORD_W = PA_DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = PA_DATA_WIDTH;
`endif

  logic [STATE_W-1:0]       state, state_d;
  logic [PA_ADDR_WIDTH-1:0] mar, mar_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic                     mar_wr_ack_d, ram_wr_ack_d, ram_oe_ack_d;
  logic [PA_DATA_WIDTH-1:0] data_out_d;
  logic                     busy_d;
  logic                     ram_we_c;
  logic                     hold_req_c;
  logic [WORD_W-1:0]        ram_wdata_c;
  logic [WORD_W-1:0]        ram_rdata;
`ifdef RAM_RESP_PARITY_EN
  logic                     par_err_d;
`endif

  // Stored word: data plus optional even-parity bit on top.
`ifdef RAM_RESP_PARITY_EN
  assign ram_wdata_c = {^data_in, data_in};
`else
  assign ram_wdata_c = data_in;
`endif

  // Request belonging to whichever ack is currently held.
  assign hold_req_c = (mar_wr_ack & mar_wr) | (ram_wr_ack & ram_wr) | (ram_oe_ack & ram_oe);

  ram_array #(
    .DATA_WIDTH (WORD_W),
    .ADDR_WIDTH (PA_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (mar),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    mar_d        = mar;
    cnt_d        = cnt;
    mar_wr_ack_d = mar_wr_ack;
    ram_wr_ack_d = ram_wr_ack;
    ram_oe_ack_d = ram_oe_ack;
    data_out_d   = data_out;
    ram_we_c     = 1'b0;
`ifdef RAM_RESP_PARITY_EN
    par_err_d    = par_err;
`endif

    case (state)
      ST_IDLE: begin
        if (mar_wr) begin
          mar_d   = addr_in;
          state_d = ST_MAR;
        end else if (ram_wr) begin
          ram_we_c = 1'b1;
          state_d  = ST_WRITE;
        end else if (ram_oe) begin
          cnt_d   = '0;
          state_d = ST_READ_WAIT;
        end
      end
      ST_MAR: begin
        mar_wr_ack_d = 1'b1;
        state_d      = ST_ACK_HOLD;
      end
      ST_WRITE: begin
        ram_wr_ack_d = 1'b1;
        state_d      = ST_ACK_HOLD;
      end
      ST_READ_WAIT: begin
        // The RAM read register already holds RAM[MAR]; MAR cannot change here.
        if (cnt == CNT_W'(PA_RD_LAT)) begin
          ram_oe_ack_d = 1'b1;
          data_out_d   = ram_rdata[PA_DATA_WIDTH-1:0];
`ifdef RAM_RESP_PARITY_EN
          par_err_d    = ^ram_rdata;
`endif
          cnt_d        = '0;
          state_d      = ST_ACK_HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_ACK_HOLD: begin
        if (!hold_req_c) begin
          mar_wr_ack_d = 1'b0;
          ram_wr_ack_d = 1'b0;
          ram_oe_ack_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        mar_wr_ack_d = 1'b0;
        ram_wr_ack_d = 1'b0;
        ram_oe_ack_d = 1'b0;
        cnt_d        = '0;
        state_d      = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // Reset wins over a same-edge write request.
    if (rst_b) begin
      ram_we_c = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= ST_IDLE;
      mar        <= '0;
      cnt        <= '0;
      mar_wr_ack <= 1'b0;
      ram_wr_ack <= 1'b0;
      ram_oe_ack <= 1'b0;
      data_out   <= '0;
      busy       <= 1'b0;
`ifdef RAM_RESP_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      mar        <= mar_d;
      cnt        <= cnt_d;
      mar_wr_ack <= mar_wr_ack_d;
      ram_wr_ack <= ram_wr_ack_d;
      ram_oe_ack <= ram_oe_ack_d;
      data_out   <= data_out_d;
      busy       <= busy_d;
`ifdef RAM_RESP_PARITY_EN
      par_err    <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder (default parameters).
module tb_ram_responder;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 8;
  localparam int unsigned RD_LAT = 2;

  logic          clk;
  logic          rst_b;
  logic          mar_wr, ram_wr, ram_oe;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          mar_wr_ack, ram_wr_ack, ram_oe_ack;
  logic [DW-1:0] data_out;
  logic          busy;
`ifdef RAM_RESP_PARITY_EN
  logic          par_err;
`endif
  logic [2:0]    acks;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] mem_m [256];
  bit            valid_m [256];
  logic [AW-1:0] mar_m;
  logic [DW-1:0] dout_m;
  bit            dout_known;

  ram_responder #(
    .PA_DATA_WIDTH (DW),
    .PA_ADDR_WIDTH (AW),
    .PA_RD_LAT     (RD_LAT)
  ) u_dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .mar_wr     (mar_wr),
    .addr_in    (addr_in),
    .mar_wr_ack (mar_wr_ack),
    .ram_wr     (ram_wr),
    .data_in    (data_in),
    .ram_wr_ack (ram_wr_ack),
    .ram_oe     (ram_oe),
    .ram_oe_ack (ram_oe_ack),
    .data_out   (data_out),
    .busy       (busy)
`ifdef RAM_RESP_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  assign acks = {ram_oe_ack, ram_wr_ack, mar_wr_ack};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_req(input int which, input logic v);
    case (which)
      0: mar_wr = v;
      1: ram_wr = v;
      default: ram_oe = v;
    endcase
  endtask

  // Counts negedges until the selected ack is seen; flags any foreign ack.
  task automatic wait_ack(input int which, output int n, output bit ov);
    n  = 0;
    ov = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if ((acks & ~(3'b001 << which)) != 3'b000) ov = 1'b1;
    end while (!acks[which] && n < 30);
  endtask

  // Holds the request for a few cycles, drops it, samples one cycle later.
  task automatic finish_hs(input int which, input int hold, output bit held,
                           output logic ack_after, output logic busy_after);
    held = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!acks[which]) held = 1'b0;
    end
    set_req(which, 1'b0);
    @(negedge clk);
    ack_after  = acks[which];
    busy_after = busy;
  endtask

  // Complete handshake for setup steps, with model updates.
  task automatic op(input int which, input logic [31:0] val);
    int n; bit ov, held; logic a, b;
    if (which == 0) addr_in = AW'(val);
    if (which == 1) data_in = val;
    set_req(which, 1'b1);
    wait_ack(which, n, ov);
    finish_hs(which, 0, held, a, b);
    if (which == 0) mar_m = AW'(val);
    if (which == 1) begin mem_m[mar_m] = val; valid_m[mar_m] = 1'b1; end
    if (which == 2) begin dout_m = mem_m[mar_m]; dout_known = valid_m[mar_m]; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_b = 1'b1; mar_wr = 0; ram_wr = 0; ram_oe = 0; addr_in = '0; data_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b expected 000", acks); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    rst_b = 1'b0;
    mar_m = '0; dout_m = '0; dout_known = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mar_write;
    int n; bit ov, held; logic a, b;
    addr_in = 8'h05; mar_wr = 1'b1;
    wait_ack(0, n, ov);
    checks++; if (n !== 2 || ov) begin errors++; $display("FAIL mar_ack_latency: got %0d (ov=%0d) expected 2", n, ov); end
    finish_hs(0, 1, held, a, b);
    checks++; if (!held || a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL mar_ack_fall: held=%0d ack=%b busy=%b expected 1/0/0", held, a, b); end
    mar_m = 8'h05;
    data_in = 32'hDEADBEEF; ram_wr = 1'b1;
    wait_ack(1, n, ov);
    checks++; if (n !== 2 || ov) begin errors++; $display("FAIL wr_ack_latency: got %0d (ov=%0d) expected 2", n, ov); end
    finish_hs(1, 2, held, a, b);
    checks++; if (!held || a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL wr_ack_fall: held=%0d ack=%b busy=%b expected 1/0/0", held, a, b); end
    mem_m[8'h05] = 32'hDEADBEEF; valid_m[8'h05] = 1'b1;
  endtask

  task automatic test_read_latency;
    int n; bit ov, held; logic a, b;
    op(0, 32'h05);
    ram_oe = 1'b1;
    wait_ack(2, n, ov);
    checks++; if (n !== int'(RD_LAT) + 2 || ov) begin errors++; $display("FAIL rd_ack_latency: got %0d (ov=%0d) expected %0d", n, ov, RD_LAT + 2); end
    checks++; if (data_out !== mem_m[8'h05]) begin errors++; $display("FAIL rd_data: got %h expected %h", data_out, mem_m[8'h05]); end
    finish_hs(2, 1, held, a, b);
    checks++; if (!held || a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL rd_ack_fall: held=%0d ack=%b busy=%b expected 1/0/0", held, a, b); end
    dout_m = mem_m[8'h05]; dout_known = 1'b1;
    checks++; if (data_out !== dout_m) begin errors++; $display("FAIL rd_data_hold: got %h expected %h", data_out, dout_m); end
  endtask

  task automatic test_wrap;
    op(0, 32'h00); op(1, 32'h0BADF00D);
    op(0, 32'hFF); op(1, 32'h00000001);
    op(0, 32'hFF); op(2, 32'h0);
    checks++; if (data_out !== 32'h1) begin errors++; $display("FAIL wrap_ff: got %h expected 00000001", data_out); end
    op(0, 32'h00); op(2, 32'h0);
    checks++; if (data_out !== 32'h0BADF00D) begin errors++; $display("FAIL wrap_00: got %h expected 0badf00d", data_out); end
  endtask

  task automatic test_reset_wins;
    op(0, 32'h07);
    rst_b = 1'b1; mar_wr = 1'b1; addr_in = 8'h05;
    @(negedge clk);
    mar_wr = 1'b0; ram_wr = 1'b1; data_in = 32'hFFFF0000;
    @(negedge clk);
    rst_b = 1'b0; ram_wr = 1'b0;
    mar_m = '0; dout_m = '0;
    checks++; if (acks !== 3'b000 || busy !== 1'b0 || data_out !== '0) begin errors++; $display("FAIL reset_wins_state: acks=%b busy=%b dout=%h expected 000/0/0", acks, busy, data_out); end
    op(2, 32'h0);
    checks++; if (data_out !== mem_m[8'h00]) begin errors++; $display("FAIL reset_wins_mem: got %h expected %h", data_out, mem_m[8'h00]); end
  endtask

  task automatic test_simultaneous;
    int n; bit ov, held; logic a, b;
    addr_in = 8'h10; data_in = 32'hA5A50001;
    mar_wr = 1'b1; ram_wr = 1'b1; ram_oe = 1'b1;
    wait_ack(0, n, ov);
    checks++; if (n !== 2 || ov) begin errors++; $display("FAIL sim_mar_first: got %0d (ov=%0d) expected 2", n, ov); end
    finish_hs(0, 0, held, a, b);
    mar_m = 8'h10;
    wait_ack(1, n, ov);
    checks++; if (n !== 2 || ov) begin errors++; $display("FAIL sim_wr_second: got %0d (ov=%0d) expected 2", n, ov); end
    finish_hs(1, 0, held, a, b);
    mem_m[8'h10] = 32'hA5A50001; valid_m[8'h10] = 1'b1;
    wait_ack(2, n, ov);
    checks++; if (n !== int'(RD_LAT) + 2 || ov) begin errors++; $display("FAIL sim_rd_third: got %0d (ov=%0d) expected %0d", n, ov, RD_LAT + 2); end
    checks++; if (data_out !== mem_m[8'h10]) begin errors++; $display("FAIL sim_rd_data: got %h expected %h", data_out, mem_m[8'h10]); end
    finish_hs(2, 0, held, a, b);
    dout_m = mem_m[8'h10]; dout_known = 1'b1;
    checks++; if (a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL sim_idle: ack=%b busy=%b expected 0/0", a, b); end
  endtask

  task automatic test_reset_mid_read;
    bit late_ack;
    op(0, 32'h05);
    ram_oe = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b1; ram_oe = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    mar_m = '0; dout_m = '0; dout_known = 1'b1;
    checks++; if (acks !== 3'b000 || data_out !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_read_reset: acks=%b dout=%h busy=%b expected 000/0/0", acks, data_out, busy); end
    late_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (acks !== 3'b000) late_ack = 1'b1;
    end
    checks++; if (late_ack) begin errors++; $display("FAIL mid_read_no_ack: got late ack expected none"); end
    op(0, 32'h05); op(2, 32'h0);
    checks++; if (data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_read_mem: got %h expected deadbeef", data_out); end
  endtask

  task automatic test_random;
    int n, w, exp_n; bit ov, held, early; logic a, b;
    logic [AW-1:0] sa; logic [DW-1:0] sd;
    for (int it = 0; it < 60; it++) begin
      w = $urandom_range(0, 2);
      if (dout_known) begin
        checks++; if (data_out !== dout_m) begin errors++; $display("FAIL rnd_hold[%0d]: got %h expected %h", it, data_out, dout_m); end
      end
      sa = ($urandom_range(0, 3) == 0) ? 8'hFF : AW'($urandom_range(0, 7));
      sd = $urandom;
      addr_in = sa; data_in = sd;
      set_req(w, 1'b1);
      @(negedge clk);
      addr_in = AW'($urandom); data_in = $urandom;
      early = ($urandom_range(0, 3) == 0);
      if (early) set_req(w, 1'b0);
      wait_ack(w, n, ov);
      n++;
      exp_n = (w == 2) ? int'(RD_LAT) + 2 : 2;
      checks++; if (n !== exp_n || ov) begin errors++; $display("FAIL rnd_latency[%0d] op%0d: got %0d (ov=%0d) expected %0d", it, w, n, ov, exp_n); end
      if (w == 0) mar_m = sa;
      if (w == 1) begin mem_m[mar_m] = sd; valid_m[mar_m] = 1'b1; end
      if (w == 2) begin
        dout_known = valid_m[mar_m]; dout_m = mem_m[mar_m];
        if (dout_known) begin
          checks++; if (data_out !== dout_m) begin errors++; $display("FAIL rnd_read[%0d] addr %h: got %h expected %h", it, mar_m, data_out, dout_m); end
        end
      end
      if (early) begin
        @(negedge clk);
        checks++; if (acks[w] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d]: ack=%b busy=%b expected 0/0", it, acks[w], busy); end
      end else begin
        finish_hs(w, $urandom_range(0, 2), held, a, b);
        checks++; if (!held || a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL rnd_release[%0d]: held=%0d ack=%b busy=%b expected 1/0/0", it, held, a, b); end
      end
    end
  endtask

`ifdef RAM_RESP_PARITY_EN
  task automatic test_parity;
    op(0, 32'h20); op(1, 32'h13572468);
    u_dut.u_ram.mem[8'h20][DW] = ~u_dut.u_ram.mem[8'h20][DW];
    op(2, 32'h0);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", par_err); end
    op(0, 32'h21); op(1, 32'h13572469); op(2, 32'h0);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL parity_clean: got %b expected 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_mar_write();
    test_read_latency();
    test_wrap();
    test_reset_wins();
    test_simultaneous();
    test_reset_mid_read();
    test_random();
`ifdef RAM_RESP_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
